// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bank codes, data width and arbiter state encoding
package bus_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [3:0] BANK_ROM    = 4'd0;
  localparam logic [3:0] BANK_CART   = 4'd1;
  localparam logic [3:0] BANK_EEPROM = 4'd2;
  localparam logic [3:0] BANK_SD     = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational wrap-around first-set picker from a start index
module rr_picker
  import bus_pkg::*;
#(
  parameter int N           = 2,
  parameter int ROUND_ROBIN = 1,
  localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [IW-1:0] base;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  assign base = (ROUND_ROBIN != 0) ? start : '0;

  // One extra bit on the sum lets the wrap be a single conditional subtract.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, base} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
      if (!valid && request[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        index      = idx;
      end
    end
  end

endmodule

// File: rtl/device_arbiter_rr.sv
// rtl/device_arbiter_rr.sv - bank-filtered N-controller arbiter onto one device port
// Optional ack watchdog compiled in with DEVICE_ARBITER_TIMEOUT_EN.
module device_arbiter_rr
  import bus_pkg::*;
#(
  parameter int         NUM_CONTROLLERS = 2,
  parameter int         ADDRESS_WIDTH   = 25,
  parameter logic [3:0] DEVICE_BANK     = 4'd0,
  parameter int         ROUND_ROBIN     = 1,
  parameter int         TIMEOUT_CYCLES  = 1024,
  localparam int        N               = NUM_CONTROLLERS,
  localparam int        GW              = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N-1:0]               i_request,
  input  logic [N-1:0]               i_write,
  input  logic [4*N-1:0]             i_bank,
  input  logic [ADDRESS_WIDTH*N-1:0] i_address,
  input  logic [DATA_WIDTH*N-1:0]    i_data,
  output logic [N-1:0]               o_busy,
  output logic [N-1:0]               o_ack,
  output logic [DATA_WIDTH*N-1:0]    o_data,
  output logic                       o_device_request,
  output logic                       o_device_write,
  input  logic                       i_device_busy,
  input  logic                       i_device_ack,
  output logic [ADDRESS_WIDTH-1:0]   o_device_address,
  input  logic [DATA_WIDTH-1:0]      i_device_data,
  output logic [DATA_WIDTH-1:0]      o_device_data,
  output logic [GW-1:0]              o_grant,
  output logic                       o_timeout
);

  arb_state_t state, state_next;

  logic [N-1:0]  pending;
  logic [N-1:0]  accept;
  logic [N-1:0]  pick_grant;
  logic [N-1:0]  winner;
  logic [GW-1:0] pick_index;
  logic [GW-1:0] rr_start;
  logic          pick_valid;
  logic          load;
  logic          handshake;
  logic          complete;
  logic          timeout_fire;

  logic                     slot_write   [N];
  logic [ADDRESS_WIDTH-1:0] slot_address [N];
  logic [DATA_WIDTH-1:0]    slot_data    [N];

  assign o_busy = pending;

  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = i_request[i] && (i_bank[4*i +: 4] == DEVICE_BANK) && !pending[i];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N; i++) begin
      if (accept[i]) begin
        slot_write[i]   <= i_write[i];
        slot_address[i] <= i_address[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
        slot_data[i]    <= i_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  rr_picker #(
    .N           (N),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_picker (
    .request (pending),
    .start   (rr_start),
    .grant   (pick_grant),
    .index   (pick_index),
    .valid   (pick_valid)
  );

`ifdef DEVICE_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || state != ST_WAIT_ACK) begin
      wd_count <= '0;
    end else if (!timeout_fire) begin
      wd_count <= wd_count + CW'(1);
    end
  end

  assign timeout_fire = (state == ST_WAIT_ACK) && (wd_count == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // o_device_request is registered high throughout ISSUE, so the handshake is just !busy.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    handshake  = 1'b0;
    complete   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          load       = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!i_device_busy) begin
          handshake  = 1'b1;
          state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (i_device_ack || timeout_fire) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending          <= '0;
      winner           <= '0;
      rr_start         <= '0;
      o_grant          <= '0;
      o_ack            <= '0;
      o_data           <= '0;
      o_timeout        <= 1'b0;
      o_device_request <= 1'b0;
      o_device_write   <= 1'b0;
      o_device_address <= '0;
      o_device_data    <= '0;
    end else begin
      o_ack     <= '0;
      o_timeout <= complete && !i_device_ack;
      pending   <= (pending | accept) & ~(complete ? winner : '0);

      if (load) begin
        winner           <= pick_grant;
        o_grant          <= pick_index;
        rr_start         <= (pick_index == GW'(N - 1)) ? '0 : pick_index + GW'(1);
        o_device_request <= 1'b1;
        o_device_write   <= slot_write[pick_index];
        o_device_address <= slot_address[pick_index];
        o_device_data    <= slot_data[pick_index];
      end

      if (handshake) begin
        o_device_request <= 1'b0;
      end

      // A real ack wins over a watchdog expiry landing in the same cycle.
      if (complete) begin
        o_ack <= winner;
        for (int i = 0; i < N; i++) begin
          if (winner[i]) begin
            o_data[DATA_WIDTH*i +: DATA_WIDTH] <= i_device_ack ? i_device_data : '1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_device_arbiter_rr.sv
// tb/tb_device_arbiter_rr.sv - randomized self-checking bench for device_arbiter_rr
module tb_device_arbiter_rr;
  import bus_pkg::*;

  localparam int         NC   = 4;
  localparam int         AW   = 25;
  localparam logic [3:0] BANK = BANK_CART;
  localparam int         TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [NC-1:0]    req = '0, wr = '0;
  logic [4*NC-1:0]  bank = '0;
  logic [AW*NC-1:0] addr = '0;
  logic [32*NC-1:0] wdata = '0;
  logic             dev_busy = 1'b0, dev_ack = 1'b0;
  logic [31:0]      dev_rdata = '0;

  logic [NC-1:0]    m_busy, m_ack, f_busy, f_ack;
  logic [32*NC-1:0] m_data, f_data;
  logic             m_dreq, m_dwr, m_to, f_dreq, f_dwr, f_to;
  logic [AW-1:0]    m_daddr, f_daddr;
  logic [31:0]      m_ddata, f_ddata;
  logic [1:0]       m_grant, f_grant;

  logic             sel = 1'b0;
  logic [NC-1:0]    v_busy, v_ack;
  logic [32*NC-1:0] v_data;
  logic             v_dreq, v_dwr;
  logic [AW-1:0]    v_daddr;
  logic [31:0]      v_ddata;
  logic [1:0]       v_grant;

  assign v_busy  = sel ? f_busy  : m_busy;
  assign v_ack   = sel ? f_ack   : m_ack;
  assign v_data  = sel ? f_data  : m_data;
  assign v_dreq  = sel ? f_dreq  : m_dreq;
  assign v_dwr   = sel ? f_dwr   : m_dwr;
  assign v_daddr = sel ? f_daddr : m_daddr;
  assign v_ddata = sel ? f_ddata : m_ddata;
  assign v_grant = sel ? f_grant : m_grant;

  device_arbiter_rr #(.NUM_CONTROLLERS(NC), .ADDRESS_WIDTH(AW), .DEVICE_BANK(BANK),
                      .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO)) u_rr (
    .i_clk(clk), .i_reset(rst), .i_request(req), .i_write(wr), .i_bank(bank),
    .i_address(addr), .i_data(wdata), .o_busy(m_busy), .o_ack(m_ack), .o_data(m_data),
    .o_device_request(m_dreq), .o_device_write(m_dwr), .i_device_busy(dev_busy),
    .i_device_ack(dev_ack), .o_device_address(m_daddr), .i_device_data(dev_rdata),
    .o_device_data(m_ddata), .o_grant(m_grant), .o_timeout(m_to));

  device_arbiter_rr #(.NUM_CONTROLLERS(NC), .ADDRESS_WIDTH(AW), .DEVICE_BANK(BANK),
                      .ROUND_ROBIN(0), .TIMEOUT_CYCLES(TO)) u_fp (
    .i_clk(clk), .i_reset(rst), .i_request(req), .i_write(wr), .i_bank(bank),
    .i_address(addr), .i_data(wdata), .o_busy(f_busy), .o_ack(f_ack), .o_data(f_data),
    .o_device_request(f_dreq), .o_device_write(f_dwr), .i_device_busy(dev_busy),
    .i_device_ack(dev_ack), .o_device_address(f_daddr), .i_device_data(dev_rdata),
    .o_device_data(f_ddata), .o_grant(f_grant), .o_timeout(f_to));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: set of accepted-but-unserved slots and the contents they latched.
  logic [NC-1:0] mp;
  int            last;
  logic          md_wr   [NC];
  logic [AW-1:0] md_addr [NC];
  logic [31:0]   md_data [NC];

  function automatic int pick_model(input logic [NC-1:0] p, input int lst, input int rr);
    int s;
    int j;
    s = rr ? (lst + 1) % NC : 0;
    for (int k = 0; k < NC; k++) begin
      j = (s + k) % NC;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_slot(input int i, input logic w, input logic [3:0] b,
                          input logic [AW-1:0] a, input logic [31:0] d);
    wr[i] = w;
    bank[4*i +: 4] = b;
    addr[AW*i +: AW] = a;
    wdata[32*i +: 32] = d;
    if (b == BANK) begin
      md_wr[i] = w;
      md_addr[i] = a;
      md_data[i] = d;
    end
  endtask

  task automatic pulse_req(input logic [NC-1:0] mask);
    req = mask;
    @(negedge clk);
    req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    dev_busy = 1'b0;
    dev_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mp = '0;
    last = NC - 1;
  endtask

  // Plays the device for one transaction and reports what it saw; returns at the o_ack cycle.
  task automatic dev_serve(input int bcyc, input logic [31:0] rd, output bit got,
                           output logic [AW-1:0] oa, output logic ow, output logic [31:0] od,
                           output logic [1:0] og, output bit stable, output logic [NC-1:0] oack,
                           output logic [32*NC-1:0] odata, output logic [NC-1:0] obusy,
                           output int t_ack, output int hs);
    got = 0; stable = 1; hs = 0; oa = '0; ow = 0; od = '0; og = '0;
    oack = '0; odata = '0; obusy = '0; t_ack = 0;
    for (int c = 0; c < 20; c++) begin
      if (v_dreq === 1'b1) break;
      @(negedge clk);
    end
    if (v_dreq !== 1'b1) return;
    got = 1;
    oa = v_daddr; ow = v_dwr; od = v_ddata; og = v_grant;
    dev_busy = (bcyc > 0);
    for (int c = 0; c < bcyc; c++) begin
      @(negedge clk);
      if (v_dreq !== 1'b1 || v_daddr !== oa || v_ddata !== od || v_dwr !== ow) stable = 0;
      if (c == bcyc - 1) dev_busy = 1'b0;
    end
    hs = 1;
    @(negedge clk);
    if (v_dreq === 1'b1) hs++;
    dev_ack = 1'b1;
    dev_rdata = rd;
    @(negedge clk);
    dev_ack = 1'b0;
    if (v_dreq === 1'b1) hs++;
    oack = v_ack; odata = v_data; obusy = v_busy; t_ack = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_busy, m_ack, m_dreq, m_dwr, m_to, m_grant} !== '0) begin
      errors++; $display("FAIL reset_ctrl got %h want 0", {m_busy, m_ack, m_dreq, m_dwr, m_to, m_grant});
    end
    checks++;
    if ({m_data, m_daddr, m_ddata} !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", {m_data, m_daddr, m_ddata});
    end
    do_reset();
  endtask

  task automatic test_single_read();
    bit got, stb; logic [AW-1:0] oa; logic ow; logic [31:0] od; logic [1:0] og;
    logic [NC-1:0] oack, obusy; logic [32*NC-1:0] odata; int tack, hs, tacc;
    sel = 1'b0;
    set_slot(0, 1'b0, BANK, 25'h10, $urandom);
    tacc = cyc;
    pulse_req(4'b0001);
    dev_serve(0, 32'hDEADBEEF, got, oa, ow, od, og, stb, oack, odata, obusy, tack, hs);
    checks++;
    if (!got) begin errors++; $display("FAIL single_req_timeout got 0 want 1"); return; end
    checks++;
    if (oa !== 25'h10 || ow !== 1'b0) begin
      errors++; $display("FAIL single_addr got %h/%b want 10/0", oa, ow);
    end
    checks++;
    if (tack - tacc !== 4) begin errors++; $display("FAIL single_latency got %0d want 4", tack - tacc); end
    checks++;
    if (oack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", oack); end
    checks++;
    if (odata[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_data got %h want deadbeef", odata[31:0]);
    end
    checks++;
    if (obusy !== 4'b0000) begin errors++; $display("FAIL single_busy got %b want 0000", obusy); end
    @(negedge clk);
    checks++;
    if (m_ack !== 4'b0000 || m_data[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_hold got %b/%h want 0000/deadbeef", m_ack, m_data[31:0]);
    end
  endtask

  task automatic test_bank_filter();
    bit bad_busy = 0, bad_req = 0;
    sel = 1'b0;
    set_slot(1, 1'b1, BANK_SD, $urandom, $urandom);
    pulse_req(4'b0010);
    for (int c = 0; c < 6; c++) begin
      if (m_busy[1] !== 1'b0) bad_busy = 1;
      if (m_dreq !== 1'b0) bad_req = 1;
      @(negedge clk);
    end
    checks++;
    if (bad_busy) begin errors++; $display("FAIL bank_busy got 1 want 0"); end
    checks++;
    if (bad_req) begin errors++; $display("FAIL bank_devreq got 1 want 0"); end
  endtask

  task automatic test_rr_fairness();
    bit got, stb; logic [AW-1:0] oa; logic ow; logic [31:0] od, rd; logic [1:0] og;
    logic [NC-1:0] oack, obusy; logic [32*NC-1:0] odata; int tack, hs, w, nw;
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < NC; i++) set_slot(i, 1'($urandom), BANK, $urandom, $urandom);
    pulse_req('1);
    mp = '1;
    w = pick_model(mp, last, 1);
    for (int r = 0; r < 5; r++) begin
      rd = $urandom;
      dev_serve(0, rd, got, oa, ow, od, og, stb, oack, odata, obusy, tack, hs);
      checks++;
      if (!got) begin errors++; $display("FAIL rr_req_timeout round %0d", r); return; end
      checks++;
      if (og !== 2'(w)) begin errors++; $display("FAIL rr_grant round %0d got %0d want %0d", r, og, w); end
      checks++;
      if (oa !== md_addr[w] || od !== md_data[w]) begin
        errors++; $display("FAIL rr_payload got %h/%h want %h/%h", oa, od, md_addr[w], md_data[w]);
      end
      checks++;
      if (oack !== (4'b1 << w) || odata[32*w +: 32] !== rd) begin
        errors++; $display("FAIL rr_ack got %b/%h want %b/%h", oack, odata[32*w +: 32], 4'b1 << w, rd);
      end
      mp[w] = 1'b0;
      last = w;
      nw = pick_model(mp, last, 1);
      set_slot(w, 1'($urandom), BANK, $urandom, $urandom);
      pulse_req(4'b1 << w);
      mp[w] = 1'b1;
      w = nw;
    end
  endtask

  task automatic test_device_busy();
    bit got, stb; logic [AW-1:0] oa; logic ow; logic [31:0] od, rd; logic [1:0] og;
    logic [NC-1:0] oack, obusy; logic [32*NC-1:0] odata; int tack, hs;
    do_reset();
    sel = 1'b0;
    set_slot(2, 1'b1, BANK, $urandom, $urandom);
    pulse_req(4'b0100);
    rd = $urandom;
    dev_serve(5, rd, got, oa, ow, od, og, stb, oack, odata, obusy, tack, hs);
    checks++;
    if (!got) begin errors++; $display("FAIL busy_req_timeout got 0 want 1"); return; end
    checks++;
    if (!stb) begin errors++; $display("FAIL busy_stable got 0 want 1"); end
    checks++;
    if (hs !== 1) begin errors++; $display("FAIL busy_handshakes got %0d want 1", hs); end
    checks++;
    if (oa !== md_addr[2] || od !== md_data[2] || ow !== 1'b1 || oack !== 4'b0100) begin
      errors++; $display("FAIL busy_txn got %h/%h/%b/%b want %h/%h/1/0100", oa, od, ow, oack, md_addr[2], md_data[2]);
    end
  endtask

  task automatic test_reset_wait_ack();
    bit bad = 0;
    do_reset();
    sel = 1'b0;
    set_slot(3, 1'b0, BANK, $urandom, $urandom);
    pulse_req(4'b1000);
    for (int c = 0; c < 20; c++) begin
      if (m_dreq === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (m_dreq !== 1'b1) begin errors++; $display("FAIL rstwait_req_timeout got 0 want 1"); return; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_busy, m_ack, m_dreq, m_dwr, m_to, m_grant, m_data, m_daddr, m_ddata} !== '0) begin
      errors++; $display("FAIL rstwait_outputs got %h want 0", {m_busy, m_ack, m_dreq, m_grant, m_daddr});
    end
    rst = 1'b0;
    dev_ack = 1'b1;
    dev_rdata = $urandom;
    @(negedge clk);
    dev_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (m_ack !== '0 || m_dreq !== 1'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstwait_late_ack got activity want none"); end
  endtask

  task automatic test_random(input int fp, input int iters);
    bit got, stb; logic [AW-1:0] oa; logic ow; logic [31:0] od, rd; logic [1:0] og;
    logic [NC-1:0] oack, obusy, mask, add; logic [32*NC-1:0] odata; int tack, hs, w;
    logic [3:0] bk;
    do_reset();
    sel = fp[0];
    for (int it = 0; it < iters; it++) begin
      w = (mp != '0) ? pick_model(mp, last, fp ? 0 : 1) : -1;
      mask = '0;
      add = '0;
      for (int i = 0; i < NC; i++) begin
        if (!mp[i] && $urandom_range(0, 2) != 0) begin
          mask[i] = 1'b1;
          bk = ($urandom_range(0, 3) == 0) ? BANK_EEPROM : BANK;
          set_slot(i, 1'($urandom), bk, $urandom, $urandom);
          if (bk == BANK) add[i] = 1'b1;
        end
      end
      if (mask != '0) pulse_req(mask);
      mp = mp | add;
      if (w < 0) w = (mp != '0) ? pick_model(mp, last, fp ? 0 : 1) : -1;
      if (w < 0) begin
        repeat (3) @(negedge clk);
        checks++;
        if (v_dreq !== 1'b0) begin errors++; $display("FAIL rand_idle_req got %b want 0", v_dreq); end
        continue;
      end
      rd = $urandom;
      dev_serve($urandom_range(0, 2), rd, got, oa, ow, od, og, stb, oack, odata, obusy, tack, hs);
      checks++;
      if (!got) begin errors++; $display("FAIL rand_req_timeout mode %0d iter %0d", fp, it); return; end
      checks++;
      if (og !== 2'(w) || oa !== md_addr[w] || ow !== md_wr[w] || od !== md_data[w]) begin
        errors++;
        $display("FAIL rand_issue mode %0d got %0d/%h/%b/%h want %0d/%h/%b/%h", fp, og, oa, ow, od,
                 w, md_addr[w], md_wr[w], md_data[w]);
      end
      checks++;
      if (oack !== (4'b1 << w) || odata[32*w +: 32] !== rd) begin
        errors++; $display("FAIL rand_ack mode %0d got %b/%h want %b/%h", fp, oack, odata[32*w +: 32], 4'b1 << w, rd);
      end
      mp[w] = 1'b0;
      last = w;
      checks++;
      if (obusy !== mp) begin errors++; $display("FAIL rand_busy mode %0d got %b want %b", fp, obusy, mp); end
    end
  endtask

`ifdef DEVICE_ARBITER_TIMEOUT_EN
  task automatic test_watchdog();
    int th, tfire;
    logic [NC-1:0] ack_seen;
    logic [31:0] data_seen;
    do_reset();
    sel = 1'b0;
    set_slot(0, 1'b0, BANK, $urandom, $urandom);
    pulse_req(4'b0001);
    for (int c = 0; c < 20; c++) begin
      if (m_dreq === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (m_dreq !== 1'b1) begin errors++; $display("FAIL wd_req_timeout got 0 want 1"); return; end
    th = cyc;
    tfire = -1;
    ack_seen = '0;
    data_seen = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_to === 1'b1) begin
        tfire = cyc; ack_seen = m_ack; data_seen = m_data[31:0];
        break;
      end
    end
    checks++;
    if (tfire - th !== TO + 1) begin errors++; $display("FAIL wd_timing got %0d want %0d", tfire - th, TO + 1); end
    checks++;
    if (ack_seen !== 4'b0001 || data_seen !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL wd_ack got %b/%h want 0001/ffffffff", ack_seen, data_seen);
    end
    dev_ack = 1'b1;
    @(negedge clk);
    dev_ack = 1'b0;
    checks++;
    if (m_ack !== '0 || m_to !== 1'b0) begin errors++; $display("FAIL wd_late_ack got %b/%b want 0/0", m_ack, m_to); end
  endtask
`else
  task automatic test_no_timeout();
    bit fired = 0, acked = 0;
    do_reset();
    sel = 1'b0;
    set_slot(0, 1'b0, BANK, $urandom, $urandom);
    pulse_req(4'b0001);
    for (int c = 0; c < 3 * TO; c++) begin
      if (m_to !== 1'b0) fired = 1;
      if (m_ack !== '0) acked = 1;
      @(negedge clk);
    end
    checks++;
    if (fired) begin errors++; $display("FAIL nowd_timeout got 1 want 0"); end
    checks++;
    if (acked) begin errors++; $display("FAIL nowd_ack got 1 want 0"); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    mp = '0;
    last = NC - 1;
    test_reset();
    test_single_read();
    test_bank_filter();
    test_rr_fairness();
    test_device_busy();
    test_reset_wait_ack();
    test_random(0, 40);
    test_random(1, 40);
`ifdef DEVICE_ARBITER_TIMEOUT_EN
    test_watchdog();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/device_arbiter_rr.md
# device_arbiter_rr

Parametrised successor to the fixed two-controller device arbiter: it accepts single-word read/write requests from NUM_CONTROLLERS bus controllers (N64 PI, PC USB, future DMA masters), filters them by bank, and serialises them onto one device port. It supports round-robin or fixed-priority selection, per-controller request latching and an optional ack watchdog. One instance sits in front of each shared device (cart control, SDRAM, EEPROM, SD) in the top level.

## Interface
- NUM_CONTROLLERS, 2, number of controller ports; legal range 2..8.
- ADDRESS_WIDTH, 25, device word-address width.
- DEVICE_BANK, 0, 4-bit bank code this instance responds to.
- ROUND_ROBIN, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT_CYCLES, 1024, watchdog limit in clock cycles; used only when the watchdog is compiled in.

Ports (vectors are concatenated per controller, controller 0 in the LSBs):
- i_clk  in  1  system clock. One clock; reset is synchronous and active-high.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  N  one-cycle request strobe per controller.
- i_write  in  N  1 = write, 0 = read.
- i_bank  in  4N  bank code per controller.
- i_address  in  ADDRESS_WIDTH*N  word address per controller.
- i_data  in  32N  write data per controller.
- o_busy  out  N  controller slot occupied.
- o_ack  out  N  one-cycle completion strobe.
- o_data  out  32N  read data; valid while o_ack is high.
- o_device_request  out  1  request to device.
- o_device_write  out  1  write flag to device.
- i_device_busy  in  1  device cannot accept this cycle.
- i_device_ack  in  1  device completion; read data valid.
- o_device_address  out  ADDRESS_WIDTH  address to device.
- i_device_data  in  32  read data from device.
- o_device_data  out  32  write data to device.
- o_grant  out  clog2(N)  index of the current or last winner.
- o_timeout  out  1  watchdog fired; one-cycle pulse.

## Operation
- **Request acceptance.** A request from controller i is accepted when i_request[i], i_bank[i]==DEVICE_BANK and !o_busy[i] are all true in the same cycle.
  - Acceptance latches write, address and data into pending slot i and sets pending[i].
  - Requests whose bank does not match are ignored entirely.
  - A request made while o_busy[i] is high is dropped; the controller must not do this.
- **o_busy[i].** Equals pending[i] and is registered.
- **FSM states and transitions.**
  - IDLE: if any pending bit is set, pick a winner, load the device registers, assert o_device_request, and go to ISSUE.
  - ISSUE: hold the request, address, write flag and data stable. A cycle with o_device_request high and i_device_busy low is the handshake. Then deassert o_device_request and go to WAIT_ACK.
  - WAIT_ACK: on i_device_ack, register i_device_data into o_data[winner], pulse o_ack[winner], clear pending[winner], and return to IDLE.
- **Acks.** Writes are also acked. An i_device_ack that arrives in IDLE or ISSUE is ignored.
- **Round-robin selection.** Search starts at index (last winner + 1) mod N and wraps. After reset the search starts at 0.
- **Fixed-priority selection.** The lowest pending index wins.
- **Simultaneous events.**
  - A new acceptance on a controller other than the winner is latched while a transaction is in flight.
  - The winner's slot can accept again in the cycle after o_ack.
- **Reset.** All pending bits and the FSM clear, even mid-transaction. Every output resets to 0.

## Timing
- Acceptance at cycle T sets pending/o_busy at T+1. IDLE arbitrates at T+1, and o_device_request is high from T+2 at the earliest.
- The device handshake completes at cycle H. The earliest i_device_ack is at H+1.
- An i_device_ack at cycle A gives o_ack, o_data and the o_busy drop at A+1.
- Minimum latency from acceptance to o_ack is 4 cycles when the device is not busy and acks one cycle after the handshake.
- o_data holds its last value outside the o_ack pulse.
- Only one transaction is outstanding at a time; there is no pipelining.

## Configuration
- **With DEVICE_ARBITER_TIMEOUT_EN defined:**
  - A counter runs in WAIT_ACK and reloads to 0 on entry.
  - At TIMEOUT_CYCLES without an ack, the block pulses o_timeout, pulses o_ack[winner] with o_data = 32'hFFFF_FFFF, clears pending, and returns to IDLE.
  - A late device ack then arrives in IDLE and is ignored.
- **Without it:** there is no counter, o_timeout is tied to 0, and WAIT_ACK waits indefinitely.

## Structure
- Shared package bus_pkg holds:
  - the BANK_* codes (ROM, CART, EEPROM, SD);
  - the 32-bit data-width constant;
  - the arbiter FSM state enum.
- Sub-module rr_picker: combinational N-bit request vector plus start index in, one-hot grant plus encoded index out. With ROUND_ROBIN=0 the start index is fixed at 0.

## Test plan
- **Single read.** N=2. Controller 0 reads address 0x10. The device acks one cycle after the handshake with 0xDEADBEEF. Required: o_ack[0] exactly 4 cycles after acceptance, o_data[0]=0xDEADBEEF.
- **Bank filter.** Controller 1 requests with bank≠DEVICE_BANK. Required: o_busy[1] stays 0, and o_device_request never rises.
- **Round-robin fairness.** N=4, all four controllers request in the same cycle, each re-requesting after its ack. Required: grant order 0,1,2,3,0. With ROUND_ROBIN=0, the order is 0,0,0… while controller 0 keeps re-requesting.
- **Device busy.** i_device_busy is held high for 5 cycles. Required: address and data stay stable and the request stays high, followed by exactly one handshake.
- **Reset in WAIT_ACK.** Required: all outputs are 0 the cycle after reset, and a subsequent device ack produces no o_ack.
- **Watchdog (TIMEOUT_EN, TIMEOUT_CYCLES=8).** The device never acks. Required: o_timeout and o_ack[0] pulse 8 cycles after entering WAIT_ACK, with o_data[0]=0xFFFFFFFF.
